// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch
// Purpose  : MIPS instruction-fetch stage. Holds the PC, fetches over a
//            req/ack memory port and hands instructions to decode via
//            valid/ready. Optional macro PC_FETCH_ALIGN_CHECK_EN traps
//            misaligned next-PC values into a sticky FAULT state.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst_count,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_count_q, inst_count_d;
    logic        w_accept;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic        fault_q, fault_d;
`endif

    assign w_accept = inst_valid_q && inst_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        inst_count_d = inst_count_q;
`ifdef PC_FETCH_ALIGN_CHECK_EN
        fault_d      = fault_q;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    inst_valid_d = 1'b0;
                    inst_count_d = inst_count_q + 32'd1;
`ifdef PC_FETCH_ALIGN_CHECK_EN
                    // Misaligned target: keep the last good pc and trap.
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
`else
                    pc_d    = next_pc & c_WORD_MASK;
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            inst_count_q <= inst_count_d;
        end
    end

`ifdef PC_FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Request decodes straight from state so an async reset drops it at once.
    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign inst_count = inst_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch
// Purpose  : Self-checking bench for pc_fetch: directed scenarios with
//            literal expectations, then randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0040_0000;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    localparam bit c_ALIGN_EN = 1'b1;
`else
    localparam bit c_ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] next_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst_count;
    logic        fault;

    logic [31:0] w_next_pc = '0;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_imem_ack = 1'b0;
    logic [31:0] w_imem_rdata = '0;
    logic [31:0] w_inst;
    logic        w_inst_valid;
    logic        w_inst_ready = 1'b0;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_inst_count;
    logic        w_fault;

    int total = 0;
    int bad   = 0;

    // Behavioural model: a booted flag, a held-word flag and a dead flag.
    bit          m_booted;
    bit          m_valid;
    bit          m_dead;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_count;

    pc_fetch #(.RESET_PC(c_RESET_PC)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_pc    (next_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .inst_count (inst_count),
        .fault      (fault)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_pc    (w_next_pc),
        .imem_req   (w_imem_req),
        .imem_addr  (w_imem_addr),
        .imem_ack   (w_imem_ack),
        .imem_rdata (w_imem_rdata),
        .inst       (w_inst),
        .inst_valid (w_inst_valid),
        .inst_ready (w_inst_ready),
        .pc         (w_pc),
        .pc_plus4   (w_pc_plus4),
        .inst_count (w_inst_count),
        .fault      (w_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_booted = 1'b0;
        m_valid  = 1'b0;
        m_dead   = 1'b0;
        m_pc     = c_RESET_PC;
        m_inst   = 32'd0;
        m_count  = 32'd0;
    endfunction

    function automatic void model_step();
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (m_dead) begin
            m_dead = 1'b1;
        end else if (!m_valid) begin
            if (imem_ack) begin
                m_inst  = imem_rdata;
                m_valid = 1'b1;
            end
        end else if (inst_ready) begin
            m_valid = 1'b0;
            m_count = m_count + 32'd1;
            if (c_ALIGN_EN && (next_pc % 4 != 0))
                m_dead = 1'b1;
            else
                m_pc = next_pc - (next_pc % 4);
        end
    endfunction

    always @(negedge clk) begin
        chk("cyc_imem_req",    {31'd0, imem_req},   {31'd0, m_booted && !m_valid && !m_dead});
        chk("cyc_imem_addr",   imem_addr,           m_pc);
        chk("cyc_inst",        inst,                m_inst);
        chk("cyc_inst_valid",  {31'd0, inst_valid}, {31'd0, m_valid});
        chk("cyc_pc",          pc,                  m_pc);
        chk("cyc_pc_plus4",    pc_plus4,            m_pc + 32'd4);
        chk("cyc_inst_count",  inst_count,          m_count);
        chk("cyc_fault",       {31'd0, fault},      {31'd0, m_dead});
    end

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    // Called 1ns after a rising edge; reset lands mid-cycle.
    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_req_drop",   {31'd0, imem_req},   32'd0);
        chk("rst_valid_drop", {31'd0, inst_valid}, 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        model_reset();
        step();
        step();
        chk("reset_pc",    pc,                  c_RESET_PC);
        chk("reset_inst",  inst,                32'd0);
        chk("reset_valid", {31'd0, inst_valid}, 32'd0);
        chk("reset_count", inst_count,          32'd0);
        chk("reset_fault", {31'd0, fault},      32'd0);
        chk("reset_req",   {31'd0, imem_req},   32'd0);

        // Reset release with an ack during BOOT (ignored) and first FETCH.
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        chk("boot_req",  {31'd0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr,         32'h0040_0000);
        chk("boot_valid",{31'd0, inst_valid}, 32'd0);
        step();
        chk("first_inst",   inst,                32'h2008_0005);
        chk("first_valid",  {31'd0, inst_valid}, 32'd1);
        chk("first_plus4",  pc_plus4,            32'h0040_0004);

        // Stalled decode with stray acks carrying garbage.
        for (int i = 0; i < 5; i++) begin
            imem_ack   = i[0];
            imem_rdata = $urandom;
            next_pc    = $urandom;
            step();
            chk("stall_inst", inst, 32'h2008_0005);
            chk("stall_pc",   pc,   32'h0040_0000);
        end
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        next_pc    = 32'h0040_0004;
        step();
        inst_ready = 1'b0;
        chk("acc_pc",    pc,                32'h0040_0004);
        chk("acc_count", inst_count,        32'd1);
        chk("acc_req",   {31'd0, imem_req}, 32'd1);

        // Slow memory.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("slow_addr", imem_addr,         32'h0040_0004);
            chk("slow_req",  {31'd0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h8C0A_0000;
        step();
        chk("slow_inst", inst, 32'h8C0A_0000);
        imem_rdata = 32'hFFFF_FFFF;
        step();
        step();
        chk("stray_inst", inst, 32'h8C0A_0000);
        imem_ack = 1'b0;

        // Misaligned branch target.
        inst_ready = 1'b1;
        next_pc    = 32'h0040_0012;
        step();
        inst_ready = 1'b0;
        chk("mis_fault", {31'd0, fault},    {31'd0, c_ALIGN_EN});
        chk("mis_pc",    pc,                c_ALIGN_EN ? 32'h0040_0004 : 32'h0040_0010);
        chk("mis_count", inst_count,        32'd2);
        chk("mis_req",   {31'd0, imem_req}, {31'd0, !c_ALIGN_EN});
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("mis_req2",  {31'd0, imem_req}, 32'd0);

        // Mid-operation reset after three accepts.
        async_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            step();
            imem_ack   = 1'b0;
            inst_ready = 1'b1;
            next_pc    = c_RESET_PC + 32'd4 * (i + 1);
            step();
            inst_ready = 1'b0;
        end
        step();
        chk("mid_count", inst_count,        32'd3);
        chk("mid_req",   {31'd0, imem_req}, 32'd1);
        chk("mid_pc",    pc,                32'h0040_000C);
        async_reset();
        chk("mid_rst_pc",    pc,             c_RESET_PC);
        chk("mid_rst_count", inst_count,     32'd0);
        chk("mid_rst_fault", {31'd0, fault}, 32'd0);

        // Wrap instance, released from the same reset.
        step();
        chk("wrap_plus4", w_pc_plus4,          32'h0000_0000);
        chk("wrap_addr",  w_imem_addr,         32'hFFFF_FFFC);
        chk("wrap_req",   {31'd0, w_imem_req}, 32'd1);
        w_imem_ack   = 1'b1;
        w_imem_rdata = 32'h0000_1234;
        step();
        w_imem_ack = 1'b0;
        chk("wrap_inst",  w_inst,                32'h0000_1234);
        chk("wrap_valid", {31'd0, w_inst_valid}, 32'd1);
        w_inst_ready = 1'b1;
        w_next_pc    = 32'd0;
        step();
        w_inst_ready = 1'b0;
        chk("wrap_addr0", w_imem_addr,         32'd0);
        chk("wrap_pc0",   w_pc,                32'd0);
        chk("wrap_req0",  {31'd0, w_imem_req}, 32'd1);
        chk("wrap_cnt",   w_inst_count,        32'd1);
        chk("wrap_p4",    w_pc_plus4,          32'd4);
        chk("wrap_fault", {31'd0, w_fault},    32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            imem_ack   = ($urandom % 3) == 0;
            imem_rdata = $urandom;
            inst_ready = $urandom % 2;
            v          = $urandom;
            next_pc    = (($urandom % 8) == 0) ? v : (v & 32'hFFFF_FFFC);
            if (($urandom % 150) == 0)
                async_reset();
            else
                step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
